// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer
//   Sequences conversions on the modular ADC. Enabled channels are visited
//   round-robin with a single conversion in flight. Each channel's results are
//   boxcar-averaged over 2^AVG_LOG2 samples, and one averaged result is emitted
//   per channel per window.
//
// Ports
//   clk_clk, reset_reset_n    clock; asynchronous active-low reset
//   enable, ch_mask           run control; bit i enables ADC channel CH_BASE+i
//   cmd_*                     Avalon-ST command source toward the ADC
//   rsp_*                     Avalon-ST response sink from the ADC
//   avg_valid/_channel/_data  averaged result; avg_valid is a one-cycle strobe
//   timeout_err, err_clr      sticky "conversion abandoned" flag and its clear
//   dbg_state                 current sequencer state (state_e encoding)
//
// Handshake: a command transfers on the cycle where cmd_valid && cmd_ready.
// Once cmd_valid is raised, it and cmd_channel stay constant until that
// transfer, and nothing withdraws it (not even enable dropping). The response
// side has no back-pressure: any rsp_valid cycle is a complete beat.
module adc_channel_sequencer #(
  parameter int NUM_CH      = 8,
  parameter int CH_BASE     = 1,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              cmd_valid,
  output logic [4:0]        cmd_channel,
  output logic              cmd_sop,
  output logic              cmd_eop,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [4:0]        rsp_channel,
  input  logic [11:0]       rsp_data,
  output logic              avg_valid,
  output logic [4:0]        avg_channel,
  output logic [11:0]       avg_data,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** AVG_LOG2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_CMD    = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [ACC_W-1:0] acc_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic             avg_valid_q, avg_valid_d;
  logic [4:0]       avg_channel_q, avg_channel_d;
  logic [11:0]      avg_data_q, avg_data_d;
  logic             timeout_err_q, timeout_err_d;

  logic [PTR_W-1:0] hi_ptr, lo_ptr, next_ptr;
  logic             hi_found;
  logic [4:0]       cur_ch;
  logic             rsp_hit, tmo_hit;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_inc;

  assign cur_ch  = 5'(CH_BASE) + 5'(ptr_q);
  assign rsp_hit = rsp_valid && (rsp_channel == cur_ch);
  // Counter starts at 0 in the first WAIT cycle, so this is the last allowed cycle.
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign acc_sum = acc_q[ptr_q] + ACC_W'(rsp_data);
  assign cnt_inc = cnt_q[ptr_q] + CNT_W'(1);

  // Round-robin pick: the lowest set bit above the pointer, else wrap to the
  // lowest set bit overall. The descending scan leaves the lowest hit in each.
  always_comb begin
    hi_ptr   = '0;
    lo_ptr   = '0;
    hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lo_ptr = PTR_W'(i);
        if (PTR_W'(i) > ptr_q) begin
          hi_ptr   = PTR_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    next_ptr = hi_found ? hi_ptr : lo_ptr;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    tmo_d         = tmo_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    avg_valid_d   = 1'b0;
    avg_channel_d = avg_channel_q;
    avg_data_d    = avg_data_q;
    timeout_err_d = err_clr ? 1'b0 : timeout_err_q;

    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          acc_d[i] = '0;
          cnt_d[i] = '0;
        end
        if (enable && (|ch_mask)) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (!enable || !(|ch_mask)) begin
          state_d = S_IDLE;
        end else begin
          ptr_d   = next_ptr;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cmd_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        // A matching response on the timeout cycle takes priority over the timeout.
        if (rsp_hit) begin
          if (cnt_inc == CNT_FULL) begin
            avg_valid_d   = 1'b1;
            avg_channel_d = cur_ch;
            avg_data_d    = 12'(acc_sum >> AVG_LOG2);
            acc_d[ptr_q]  = '0;
            cnt_d[ptr_q]  = '0;
          end else begin
            acc_d[ptr_q] = acc_sum;
            cnt_d[ptr_q] = cnt_inc;
          end
          state_d = enable ? S_SELECT : S_IDLE;
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          state_d       = enable ? S_SELECT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= PTR_W'(NUM_CH - 1);
      tmo_q         <= '0;
      avg_valid_q   <= 1'b0;
      avg_channel_q <= '0;
      avg_data_q    <= '0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      tmo_q         <= tmo_d;
      avg_valid_q   <= avg_valid_d;
      avg_channel_q <= avg_channel_d;
      avg_data_q    <= avg_data_d;
      timeout_err_q <= timeout_err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Command outputs decode straight from the state flop, so reset drops them at once.
  assign cmd_valid   = (state_q == S_CMD);
  assign cmd_sop     = cmd_valid;
  assign cmd_eop     = cmd_valid;
  assign cmd_channel = cmd_valid ? cur_ch : 5'd0;

  assign avg_valid   = avg_valid_q;
  assign avg_channel = avg_channel_q;
  assign avg_data    = avg_data_q;
  assign timeout_err = timeout_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Testbench for adc_channel_sequencer.
// Two instances share all inputs: u_dut averages 4 samples (AVG_LOG2=2) and
// u_dut_p passes samples through (AVG_LOG2=0). A transaction-level model
// predicts commands, averages and the error flag. One negedge process compares
// both instances against it on every cycle. Directed sequences add literal checks.
module tb_adc_channel_sequencer;

  localparam int NUM_CH      = 8;
  localparam int CH_BASE     = 1;
  localparam int TIMEOUT_CYC = 1023;
  localparam int PH_IDLE     = 0;
  localparam int PH_PICK     = 1;
  localparam int PH_OFFER    = 2;
  localparam int PH_PEND     = 3;

  // ---------------- clock / reset / inputs ----------------
  logic        clk           = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        enable        = 1'b0;
  logic [7:0]  ch_mask       = 8'h00;
  logic        cmd_ready     = 1'b0;
  logic        rsp_valid     = 1'b0;
  logic [4:0]  rsp_channel   = 5'd0;
  logic [11:0] rsp_data      = 12'd0;
  logic        err_clr       = 1'b0;

  always #5 clk = ~clk;

  // ---------------- DUT outputs ----------------
  logic        cmd_valid, cmd_sop, cmd_eop, avg_valid, timeout_err;
  logic [4:0]  cmd_channel, avg_channel;
  logic [11:0] avg_data;
  logic [1:0]  dbg_state;
  logic        cmd_valid_p, cmd_sop_p, cmd_eop_p, avg_valid_p, timeout_err_p;
  logic [4:0]  cmd_channel_p, avg_channel_p;
  logic [11:0] avg_data_p;
  logic [1:0]  dbg_state_p;

  adc_channel_sequencer #(.NUM_CH(NUM_CH), .CH_BASE(CH_BASE), .AVG_LOG2(2), .TIMEOUT_CYC(TIMEOUT_CYC)) u_dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n), .enable(enable), .ch_mask(ch_mask),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .avg_valid(avg_valid), .avg_channel(avg_channel), .avg_data(avg_data),
    .timeout_err(timeout_err), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  adc_channel_sequencer #(.NUM_CH(NUM_CH), .CH_BASE(CH_BASE), .AVG_LOG2(0), .TIMEOUT_CYC(TIMEOUT_CYC)) u_dut_p (
    .clk_clk(clk), .reset_reset_n(reset_reset_n), .enable(enable), .ch_mask(ch_mask),
    .cmd_valid(cmd_valid_p), .cmd_channel(cmd_channel_p), .cmd_sop(cmd_sop_p), .cmd_eop(cmd_eop_p),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .avg_valid(avg_valid_p), .avg_channel(avg_channel_p), .avg_data(avg_data_p),
    .timeout_err(timeout_err_p), .err_clr(err_clr), .dbg_state(dbg_state_p)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm, input int budget);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: event not seen, expected within %0d cycles (t=%0t)", nm, budget, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models the 4-sample averager, index 1 the pass-through.
  int         phase;
  int         m_ptr;
  int         wcnt;
  logic [4:0] m_ch;
  int         acc_m [2][NUM_CH];
  int         cnt_m [2][NUM_CH];
  bit         exp_av [2];
  int         exp_ad [2];
  int         exp_ac [2];
  bit         exp_err;
  bit         m_done, m_tmo;
  int         m_nxt;

  task automatic clear_model_accs();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < NUM_CH; i++) begin
        acc_m[c][i] = 0;
        cnt_m[c][i] = 0;
      end
  endtask

  task automatic model_accept(input int data);
    for (int c = 0; c < 2; c++) begin
      int l;
      l = (c == 0) ? 2 : 0;
      acc_m[c][m_ptr] += data;
      cnt_m[c][m_ptr] += 1;
      if (cnt_m[c][m_ptr] == (1 << l)) begin
        exp_av[c] = 1'b1;
        exp_ad[c] = acc_m[c][m_ptr] / (1 << l);
        exp_ac[c] = int'(m_ch);
        acc_m[c][m_ptr] = 0;
        cnt_m[c][m_ptr] = 0;
      end
    end
  endtask

  always @(posedge clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      phase   = PH_IDLE;
      m_ptr   = NUM_CH - 1;
      wcnt    = 0;
      m_ch    = 5'd0;
      exp_err = 1'b0;
      exp_av[0] = 1'b0;
      exp_av[1] = 1'b0;
      exp_ad[0] = 0;
      exp_ad[1] = 0;
      exp_ac[0] = 0;
      exp_ac[1] = 0;
      clear_model_accs();
    end else begin
      m_done = 1'b0;
      m_tmo  = 1'b0;
      exp_av[0] = 1'b0;
      exp_av[1] = 1'b0;
      if (phase == PH_IDLE) begin
        clear_model_accs();
        if (enable && ch_mask != 8'h00) phase = PH_PICK;
      end else if (phase == PH_PICK) begin
        if (!enable || ch_mask == 8'h00) begin
          phase = PH_IDLE;
        end else begin
          m_nxt = -1;
          for (int k = 1; k <= NUM_CH; k++)
            if (m_nxt < 0 && ch_mask[(m_ptr + k) % NUM_CH]) m_nxt = (m_ptr + k) % NUM_CH;
          m_ptr = m_nxt;
          m_ch  = 5'(CH_BASE + m_ptr);
          phase = PH_OFFER;
        end
      end else if (phase == PH_OFFER) begin
        if (cmd_ready) begin
          phase = PH_PEND;
          wcnt  = 0;
        end
      end else begin
        wcnt++;
        if (rsp_valid && rsp_channel == m_ch) begin
          model_accept(int'(rsp_data));
          m_done = 1'b1;
        end else if (wcnt == TIMEOUT_CYC) begin
          m_tmo  = 1'b1;
          m_done = 1'b1;
        end
        if (m_done) begin
          if (enable) phase = PH_PICK;
          else begin
            phase = PH_IDLE;
            clear_model_accs();
          end
        end
      end
      if (m_tmo) exp_err = 1'b1;
      else if (err_clr) exp_err = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_reset_n) begin
      chk("cmd_valid", int'(cmd_valid), int'(phase == PH_OFFER));
      chk("cmd_sop", int'(cmd_sop), int'(phase == PH_OFFER));
      chk("cmd_eop", int'(cmd_eop), int'(phase == PH_OFFER));
      chk("cmd_valid_p", int'(cmd_valid_p), int'(phase == PH_OFFER));
      if (phase == PH_OFFER) begin
        chk("cmd_channel", int'(cmd_channel), int'(m_ch));
        chk("cmd_channel_p", int'(cmd_channel_p), int'(m_ch));
      end
      chk("avg_valid", int'(avg_valid), int'(exp_av[0]));
      chk("avg_valid_p", int'(avg_valid_p), int'(exp_av[1]));
      if (exp_av[0]) begin
        chk("avg_data", int'(avg_data), exp_ad[0]);
        chk("avg_channel", int'(avg_channel), exp_ac[0]);
      end
      if (exp_av[1]) begin
        chk("avg_data_p", int'(avg_data_p), exp_ad[1]);
        chk("avg_channel_p", int'(avg_channel_p), exp_ac[1]);
      end
      chk("timeout_err", int'(timeout_err), int'(exp_err));
      chk("timeout_err_p", int'(timeout_err_p), int'(exp_err));
    end
  end

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  // Wait for a command, hold ready low for rdy_dly cycles, then accept it.
  task automatic issue(input int rdy_dly, output logic [4:0] ch);
    int t;
    t = 0;
    while (!cmd_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_valid) begin
      bound_fail("cmd_appear", 20);
      ch = 5'd0;
    end else begin
      repeat (rdy_dly) @(negedge clk);
      ch = cmd_channel;
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
    end
  endtask

  // Drive one response beat in WAIT cycle dly+1, counted from the accepting edge.
  task automatic respond(input int dly, input logic [4:0] ch, input logic [11:0] data);
    repeat (dly) @(negedge clk);
    rsp_valid   = 1'b1;
    rsp_channel = ch;
    rsp_data    = data;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  // ---------------- directed sequences ----------------
  int d1 [4] = '{'h123, 'hABC, 'h000, 'hFFF};
  int d2 [4] = '{100, 101, 102, 105};

  initial begin
    logic [4:0] ch;
    int t;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_cmd_channel", int'(cmd_channel), 0);
    chk("rst_avg_valid", int'(avg_valid), 0);
    chk("rst_avg_data", int'(avg_data), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    #2 reset_reset_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_valid", int'(cmd_valid), 0);

    // Round-robin over channels 1 and 3, pass-through instance echoes every sample
    ch_mask = 8'b0000_0101;
    enable  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(0, ch);
      chk("t1_cmd_ch", int'(ch), (i % 2 == 0) ? 1 : 3);
      respond(1, ch, 12'(d1[i]));
      chk("t1_avg_valid_p", int'(avg_valid_p), 1);
      chk("t1_avg_data_p", int'(avg_data_p), d1[i]);
      chk("t1_avg_ch_p", int'(avg_channel_p), (i % 2 == 0) ? 1 : 3);
      chk("t1_avg_valid", int'(avg_valid), 0);
    end

    // enable drops while waiting: response is still consumed, then idle clears partial sums
    issue(0, ch);
    chk("t6_cmd_ch", int'(ch), 1);
    enable = 1'b0;
    respond(2, ch, 12'h200);
    chk("t6_avg_data_p", int'(avg_data_p), 'h200);
    repeat (4) @(negedge clk);
    chk("t6_idle_state", int'(dbg_state), 0);

    // 4-sample window on channel 1 (100,101,102,105 -> 408/4 = 102)
    ch_mask = 8'b0000_0001;
    enable  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(0, ch);
      chk("t2_cmd_ch", int'(ch), 1);
      respond(1, ch, 12'(d2[i]));
      chk("t2_avg_valid", int'(avg_valid), (i == 3) ? 1 : 0);
    end
    chk("t2_avg_data", int'(avg_data), 102);
    chk("t2_avg_channel", int'(avg_channel), 1);

    // Ready held low for 10 cycles
    ch_mask = 8'b0000_0101;
    issue(10, ch);
    chk("t3_cmd_ch", int'(ch), 3);
    respond(0, ch, 12'h7FF);

    // Response on a foreign channel is ignored
    issue(0, ch);
    chk("t5_pre_ch", int'(ch), 1);
    respond(0, ch, 12'h011);
    issue(0, ch);
    chk("t5_cmd_ch", int'(ch), 3);
    respond(0, 5'd7, 12'h555);
    chk("t5_ignored_p", int'(avg_valid_p), 0);
    respond(1, 5'd3, 12'h0AA);
    chk("t5_avg_data_p", int'(avg_data_p), 'h0AA);
    chk("t5_avg_ch_p", int'(avg_channel_p), 3);

    // Timeout after TIMEOUT_CYC silent cycles
    issue(0, ch);
    chk("t4_cmd_ch", int'(ch), 1);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    chk("t4_err_before", int'(timeout_err), 0);
    @(negedge clk);
    chk("t4_err_set", int'(timeout_err), 1);
    issue(0, ch);
    chk("t4_next_ch", int'(ch), 3);
    respond(0, ch, 12'h100);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t4_err_clr", int'(timeout_err), 0);

    // Matching response on the final WAIT cycle wins over the timeout
    issue(0, ch);
    chk("tb_cmd_ch", int'(ch), 1);
    respond(TIMEOUT_CYC - 1, ch, 12'h3C3);
    chk("tb_no_err", int'(timeout_err), 0);
    chk("tb_avg_data_p", int'(avg_data_p), 'h3C3);

    // err_clr on the timeout cycle: set wins
    issue(0, ch);
    chk("ts_cmd_ch", int'(ch), 3);
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ts_err_set_wins", int'(timeout_err), 1);

    // Reset while a command is being offered
    t = 0;
    while (!cmd_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_valid) bound_fail("rst_cmd_appear", 20);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_valid", int'(cmd_valid), 0);
    chk("mid_rst_cmd_valid_p", int'(cmd_valid_p), 0);
    chk("mid_rst_err", int'(timeout_err), 0);
    chk("mid_rst_avg_data", int'(avg_data), 0);
    repeat (2) @(negedge clk);
    #2 reset_reset_n = 1'b1;
    @(negedge clk);
    issue(0, ch);
    chk("post_rst_ch", int'(ch), 1);
    respond(0, ch, 12'h00F);
    chk("post_rst_avg_p", int'(avg_data_p), 'h00F);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global time bound
  initial begin
    #400000;
    bound_fail("global_watchdog", 40000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
